mem_arbiter_rr: RTL

- N-port arbiter between upstream cache-line requesters (L1I, L1D, prefetcher, ...) and one shared downstream memory port (L2 or eviction write buffer).
- Parametrised successor to the fixed two-port instruction/data arbiter; N, widths and arbitration mode are parameters.
- Registers the winning request, holds it stable downstream, routes the response back to the winner only, and counts contention for the performance unit.

---
 rtl/mem_arbiter_rr_if.sv | 31 +++
 rtl/mem_arbiter_rr.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle for mem_arbiter_rr: upstream requester lanes plus the shared downstream port.
// The slave modport is the arbiter side; the master modport drives requesters and memory.
interface mem_arbiter_rr_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0]           req_rdata;
  logic [NUM_PORTS-1:0]            req_resp;

  logic                            mem_read;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            mem_resp;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin / fixed-priority arbiter onto one downstream memory port.
// Latches the winning request, holds it until mem_resp and routes the completion back.
module mem_arbiter_rr #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RR_MODE    = 1,
  localparam int unsigned IdxW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_arbiter_rr_if.slave       bus,
  output logic [IdxW-1:0]       grant_idx,
  output logic [31:0]           conflict_count
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [IdxW-1:0]       grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [31:0]           conflict_count_q, conflict_count_d;

  logic [NUM_PORTS-1:0]  pending;
  logic                  any_pending;
  logic                  multi_pending;
  logic [IdxW-1:0]       winner;

  assign pending       = bus.req_read | bus.req_write;
  assign any_pending   = |pending;
  // Clearing the lowest set bit leaves something only if two or more ports are pending.
  assign multi_pending = |(pending & (pending - NUM_PORTS'(1)));

  // Scan upward from the base index with wrap; base is 0 in fixed-priority mode.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    base   = (RR_MODE != 0) ? 32'(rr_ptr_q) : 32'd0;
    idx    = 32'd0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      idx = (base + off) % NUM_PORTS;
      if (!found && pending[idx[IdxW-1:0]]) begin
        winner = idx[IdxW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_wdata_d      = mem_wdata_q;
    grant_idx_d      = grant_idx_q;
    rr_ptr_d         = rr_ptr_q;
    conflict_count_d = conflict_count_q;

    unique case (state_q)
      StIdle: begin
        if (any_pending) begin
          state_d       = StBusy;
          grant_idx_d   = winner;
          // A port raising both read and write is served as a write.
          mem_write_d   = bus.req_write[winner];
          mem_read_d    = bus.req_read[winner] & ~bus.req_write[winner];
          mem_address_d = bus.req_address[32'(winner) * ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d   = bus.req_wdata[32'(winner) * DATA_WIDTH +: DATA_WIDTH];
          if (multi_pending && (conflict_count_q != 32'hFFFF_FFFF)) begin
            conflict_count_d = conflict_count_q + 32'd1;
          end
        end
      end
      StBusy: begin
        if (bus.mem_resp) begin
          state_d     = StIdle;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rr_ptr_d    = (grant_idx_q == IdxW'(NUM_PORTS - 1)) ? '0 : grant_idx_q + IdxW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_wdata_q      <= '0;
      grant_idx_q      <= '0;
      rr_ptr_q         <= '0;
      conflict_count_q <= '0;
    end else begin
      state_q          <= state_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_wdata_q      <= mem_wdata_d;
      grant_idx_q      <= grant_idx_d;
      rr_ptr_q         <= rr_ptr_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  // Completion is forwarded combinationally, and only to the port holding the grant.
  always_comb begin
    bus.req_resp  = '0;
    bus.req_rdata = '0;
    if ((state_q == StBusy) && bus.mem_resp) begin
      bus.req_resp[grant_idx_q] = 1'b1;
      bus.req_rdata             = bus.mem_rdata;
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign grant_idx       = grant_idx_q;
  assign conflict_count  = conflict_count_q;

endmodule
